// File: rtl/raster_ctrl.sv
// Raster-scan sequencer for one camera frame.
// Walks a column/row counter pair across a valid/ready pixel stream.
// Emits the pixel coordinates and the line and frame boundary flags.
// Optional feature: define RASTER_FRAME_CNT_EN to add the 16-bit
// completed-frame counter output frame_cnt_o.

module counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  // Synchronous clear has priority, then count up, then count down.
  always_ff @(posedge clk_i) begin
    if (reset_i)     count_o <= '0;
    else if (up_i)   count_o <= count_o + 1'b1;
    else if (down_i) count_o <= count_o - 1'b1;
  end

endmodule

module raster_ctrl #(
  parameter int unsigned width_p  = 320,
  parameter int unsigned height_p = 240,
  parameter int unsigned cw_p     = $clog2(width_p),
  parameter int unsigned rw_p     = $clog2(height_p)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [cw_p-1:0] col_o,
  output logic [rw_p-1:0] row_o,
  output logic            sol_o,
  output logic            eol_o,
  output logic            sof_o,
  output logic            eof_o,
  output logic            busy_o,
`ifdef RASTER_FRAME_CNT_EN
  output logic [15:0]     frame_cnt_o,
`endif
  output logic            done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t    state_q;
  logic      busy_q;
  logic      done_q;
  logic      beat;
  logic      col_last;
  logic      row_last;
  logic      arm;
  logic      col_up;
  logic      col_clr;
  logic      row_up;
  logic      row_clr;
  logic [cw_p-1:0] col;
  logic [rw_p-1:0] row;

  // Handshake, beat detection and counter controls.
  always_comb begin
    beat     = busy_q & valid_i & ready_i;
    col_last = (col == cw_p'(width_p - 1));
    row_last = (row == rw_p'(height_p - 1));
    arm      = (state_q == IDLE) & start_i;
    col_up   = beat & ~col_last;
    col_clr  = reset_i | (beat & col_last) | arm;
    row_up   = beat & col_last & ~row_last;
    row_clr  = reset_i | (beat & col_last & row_last) | arm;
  end

  counter #(.width_p(cw_p)) u_col (
    .clk_i   (clk_i),
    .reset_i (col_clr),
    .up_i    (col_up),
    .down_i  (1'b0),
    .count_o (col)
  );

  counter #(.width_p(rw_p)) u_row (
    .clk_i   (clk_i),
    .reset_i (row_clr),
    .up_i    (row_up),
    .down_i  (1'b0),
    .count_o (row)
  );

  // Frame sequencer; busy and done are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (beat & col_last & row_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame count, bumped once per DONE cycle and free-wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i)                frame_cnt_q <= '0;
    else if (state_q == DONE)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  // Pass-through handshake and boundary flags from the held position.
  always_comb begin
    ready_o = busy_q & ready_i;
    valid_o = busy_q & valid_i;
    col_o   = col;
    row_o   = row;
    sol_o   = valid_o & (col == '0);
    eol_o   = valid_o & col_last;
    sof_o   = sol_o & (row == '0);
    eof_o   = eol_o & row_last;
    busy_o  = busy_q;
    done_o  = done_q;
  end

endmodule
